vending_fsm_param: RTL and testbench

- Parametrised successor to the drink-machine control FSM.
- Merges the state machine, the phase timers (pressurise/heat/dispense/sale timeout) and credit accounting into one block; timers no longer live outside.
- Generalised to N drink channels, configurable phase durations and price, with coin accumulation, change/refund output and fault recovery.
- Sits between the coin/keypad front end and the LED/actuator outputs; all timing is in `tick` periods.

---
 rtl/vending_fsm_param_if.sv | 33 +++
 rtl/vending_fsm_param.sv | 174 +++++++++++++++++
 tb/tb_vending_fsm_param.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_fsm_param_if.sv
// Bus between the coin/keypad front end and the drink-machine controller.
//   Front-end -> controller: tick, coin_valid, coin_value, drink_sel, Cancel, V_sense
//   Controller -> front-end: led_press, led_aquec, led_bebida, refund_valid,
//                            refund_amount, state, busy
// master: the front end / bench side; slave: the controller.
interface vending_fsm_param_if #(
   parameter int N_DRINKS = 2,
   parameter int CREDIT_W = 8
);
   logic                tick;
   logic                coin_valid;
   logic [CREDIT_W-1:0] coin_value;
   logic [N_DRINKS-1:0] drink_sel;
   logic                Cancel;
   logic                V_sense;
   logic                led_press;
   logic                led_aquec;
   logic [N_DRINKS-1:0] led_bebida;
   logic                refund_valid;
   logic [CREDIT_W-1:0] refund_amount;
   logic [2:0]          state;
   logic                busy;

   modport master (
      output tick, coin_valid, coin_value, drink_sel, Cancel, V_sense,
      input  led_press, led_aquec, led_bebida, refund_valid, refund_amount, state, busy
   );

   modport slave (
      input  tick, coin_valid, coin_value, drink_sel, Cancel, V_sense,
      output led_press, led_aquec, led_bebida, refund_valid, refund_amount, state, busy
   );
endinterface

// File: rtl/vending_fsm_param.sv
// Drink-machine controller: sale FSM, phase timers and credit accounting.
// Ports:
//   clk3    - system clock
//   reset_n - synchronous active-low reset
//   bus     - vending_fsm_param_if.slave (coin/keypad inputs, LED/refund/status outputs)
// All phase timing counts `tick` strobes; outputs decode the registered state.
module vending_fsm_param #(
   parameter int                  N_DRINKS = 2,
   parameter int                  CREDIT_W = 8,
   parameter logic [CREDIT_W-1:0] PRICE    = 8'd5,
   parameter int                  T_PRESS  = 2,
   parameter int                  T_HEAT   = 2,
   parameter int                  T_DISP   = 5,
   parameter int                  T_SALE   = 15
) (
   input  logic                  clk3,
   input  logic                  reset_n,
   vending_fsm_param_if.slave    bus
);

   localparam int T_MAX01 = (T_PRESS > T_HEAT) ? T_PRESS : T_HEAT;
   localparam int T_MAX23 = (T_DISP > T_SALE) ? T_DISP : T_SALE;
   localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
   localparam int TCNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SALE   = 3'd1,
      ST_PRESS  = 3'd2,
      ST_HEAT   = 3'd3,
      ST_DISP   = 3'd4,
      ST_ERROR  = 3'd5,
      ST_REFUND = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [N_DRINKS-1:0] sel_q, sel_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic                from_prep_q, from_prep_d;   // fault hit after payment was taken
   logic                coin_restart;
   logic [CREDIT_W-1:0] err_credit;
   logic                exp_press, exp_heat, exp_disp, exp_sale;
   logic                can_buy;

   function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
   endfunction

   assign exp_press = bus.tick && (tcnt_q == TCNT_W'(T_PRESS - 1));
   assign exp_heat  = bus.tick && (tcnt_q == TCNT_W'(T_HEAT - 1));
   assign exp_disp  = bus.tick && (tcnt_q == TCNT_W'(T_DISP - 1));
   assign exp_sale  = bus.tick && (tcnt_q == TCNT_W'(T_SALE - 1));
   assign can_buy   = $onehot(bus.drink_sel) && (credit_q >= PRICE);
   // Undelivered drink is handed back when leaving ERROR.
   assign err_credit = from_prep_q ? sat_add(credit_q, PRICE) : credit_q;

   always_ff @(posedge clk3) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         credit_q    <= '0;
         sel_q       <= '0;
         tcnt_q      <= '0;
         from_prep_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         sel_q       <= sel_d;
         tcnt_q      <= tcnt_d;
         from_prep_q <= from_prep_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      sel_d        = sel_q;
      from_prep_d  = from_prep_q;
      coin_restart = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.V_sense) begin
               state_d     = ST_ERROR;
               from_prep_d = 1'b0;
            end else if (bus.coin_valid) begin
               credit_d = bus.coin_value;
               state_d  = ST_SALE;
            end
         end
         ST_SALE: begin
            if (bus.V_sense) begin
               state_d     = ST_ERROR;
               from_prep_d = 1'b0;
            end else if (bus.Cancel) begin
               state_d = ST_REFUND;
            end else if (bus.coin_valid) begin
               credit_d     = sat_add(credit_q, bus.coin_value);
               coin_restart = 1'b1;
            end else if (can_buy) begin
               sel_d    = bus.drink_sel;
               credit_d = credit_q - PRICE;
               state_d  = ST_PRESS;
            end else if (exp_sale) begin
               state_d = ST_REFUND;
            end
         end
         ST_PRESS: begin
            if (bus.V_sense) begin
               state_d     = ST_ERROR;
               from_prep_d = 1'b1;
            end else if (bus.Cancel) begin
               credit_d = sat_add(credit_q, PRICE);
               state_d  = ST_REFUND;
            end else if (exp_press) begin
               state_d = ST_HEAT;
            end
         end
         ST_HEAT: begin
            if (bus.V_sense) begin
               state_d     = ST_ERROR;
               from_prep_d = 1'b1;
            end else if (exp_heat) begin
               state_d = ST_DISP;
            end
         end
         ST_DISP: begin
            if (bus.V_sense) begin
               state_d     = ST_ERROR;
               from_prep_d = 1'b1;
            end else if (exp_disp) begin
               sel_d   = '0;
               state_d = (credit_q != '0) ? ST_REFUND : ST_IDLE;
            end
         end
         ST_ERROR: begin
            if (!bus.V_sense) begin
               credit_d    = err_credit;
               sel_d       = '0;
               from_prep_d = 1'b0;
               state_d     = (err_credit != '0) ? ST_REFUND : ST_IDLE;
            end
         end
         ST_REFUND: begin
            credit_d = '0;
            sel_d    = '0;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A tick on a transition edge belongs to neither state; hold at all-ones
      // in untimed states so the counter never wraps.
      if ((state_d != state_q) || coin_restart)
         tcnt_d = '0;
      else if (bus.tick && (tcnt_q != {TCNT_W{1'b1}}))
         tcnt_d = tcnt_q + 1'b1;
      else
         tcnt_d = tcnt_q;
   end

   assign bus.led_press     = (state_q == ST_PRESS);
   assign bus.led_aquec     = (state_q == ST_HEAT);
   assign bus.led_bebida    = (state_q == ST_DISP) ? sel_q : '0;
   assign bus.refund_valid  = (state_q == ST_REFUND);
   assign bus.refund_amount = (state_q == ST_REFUND) ? credit_q : '0;
   assign bus.state         = state_q;
   assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param with a behavioural model that is
// compared against every DUT output each cycle, plus literal expectations.
module tb_vending_fsm_param;
   localparam int N = 2, W = 8, PRICE = 5, TP = 2, TH = 2, TD = 5, TS = 15;
   localparam int CMAX = (1 << W) - 1;
   localparam int S_IDLE = 0, S_SALE = 1, S_PRESS = 2, S_HEAT = 3,
                  S_DISP = 4, S_ERR = 5, S_REF = 6;

   logic clk3 = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;
   int   refunds[$];

   vending_fsm_param_if #(.N_DRINKS(N), .CREDIT_W(W)) bus();

   vending_fsm_param #(
      .N_DRINKS(N), .CREDIT_W(W), .PRICE(8'd5),
      .T_PRESS(TP), .T_HEAT(TH), .T_DISP(TD), .T_SALE(TS)
   ) dut (
      .clk3   (clk3),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk3 = ~clk3;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Model: state by spec code, credit as integer, phase time as ticks remaining.
   int m_st = S_IDLE, m_cr = 0, m_sel = 0, m_left = 0;
   bit m_fp = 1'b0;
   bit i_v, i_c, i_cv, i_tk;
   int i_val, i_sel;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   always @(posedge clk3) begin
      i_v = bus.V_sense; i_c = bus.Cancel; i_cv = bus.coin_valid; i_tk = bus.tick;
      i_val = int'(bus.coin_value); i_sel = int'(bus.drink_sel);
      if (!reset_n) begin
         m_st = S_IDLE; m_cr = 0; m_sel = 0; m_left = 0; m_fp = 0;
      end else begin
         case (m_st)
            S_IDLE:
               if (i_v) begin m_st = S_ERR; m_fp = 0; end
               else if (i_cv) begin m_cr = i_val; m_st = S_SALE; m_left = TS; end
            S_SALE:
               if (i_v) begin m_st = S_ERR; m_fp = 0; end
               else if (i_c) m_st = S_REF;
               else if (i_cv) begin m_cr = sat(m_cr + i_val); m_left = TS; end
               else if ($countones(i_sel) == 1 && m_cr >= PRICE) begin
                  m_sel = i_sel; m_cr = m_cr - PRICE; m_st = S_PRESS; m_left = TP;
               end else if (i_tk) begin
                  if (m_left == 1) m_st = S_REF; else m_left--;
               end
            S_PRESS:
               if (i_v) begin m_st = S_ERR; m_fp = 1; end
               else if (i_c) begin m_cr = sat(m_cr + PRICE); m_st = S_REF; end
               else if (i_tk) begin
                  if (m_left == 1) begin m_st = S_HEAT; m_left = TH; end else m_left--;
               end
            S_HEAT:
               if (i_v) begin m_st = S_ERR; m_fp = 1; end
               else if (i_tk) begin
                  if (m_left == 1) begin m_st = S_DISP; m_left = TD; end else m_left--;
               end
            S_DISP:
               if (i_v) begin m_st = S_ERR; m_fp = 1; end
               else if (i_tk) begin
                  if (m_left == 1) begin
                     m_sel = 0; m_st = (m_cr != 0) ? S_REF : S_IDLE;
                  end else m_left--;
               end
            S_ERR:
               if (!i_v) begin
                  if (m_fp) m_cr = sat(m_cr + PRICE);
                  m_sel = 0; m_fp = 0;
                  m_st = (m_cr != 0) ? S_REF : S_IDLE;
               end
            default: begin m_cr = 0; m_sel = 0; m_st = S_IDLE; end
         endcase
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk3) begin
      if (chk_en) begin
         check("state", int'(bus.state), m_st);
         check("led_press", int'(bus.led_press), int'(m_st == S_PRESS));
         check("led_aquec", int'(bus.led_aquec), int'(m_st == S_HEAT));
         check("led_bebida", int'(bus.led_bebida), (m_st == S_DISP) ? m_sel : 0);
         check("refund_valid", int'(bus.refund_valid), int'(m_st == S_REF));
         check("refund_amount", int'(bus.refund_amount), (m_st == S_REF) ? m_cr : 0);
         check("busy", int'(bus.busy), int'(m_st != S_IDLE));
         if (bus.refund_valid) refunds.push_back(int'(bus.refund_amount));
      end
   end

   task automatic step(input bit tk, input bit cv, input int val,
                       input logic [1:0] sl, input bit can, input bit v);
      bus.tick = tk; bus.coin_valid = cv; bus.coin_value = 8'(val);
      bus.drink_sel = sl; bus.Cancel = can; bus.V_sense = v;
      @(posedge clk3); #1;
      bus.tick = 0; bus.coin_valid = 0; bus.coin_value = '0;
      bus.drink_sel = '0; bus.Cancel = 0; bus.V_sense = 0;
   endtask

   task automatic idle();                  step(0, 0, 0, 2'b00, 0, 0); endtask
   task automatic coin(input int v);       step(0, 1, v, 2'b00, 0, 0); endtask
   task automatic pick(input logic [1:0] s); step(0, 0, 0, s, 0, 0); endtask
   task automatic cancel();                step(0, 0, 0, 2'b00, 1, 0); endtask
   task automatic fault(input bit v);      step(0, 0, 0, 2'b00, 0, v); endtask
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         idle();
         step(1, 0, 0, 2'b00, 0, 0);
      end
   endtask

   task automatic expect_refunds(input string nm, input int n, input int amt);
      check({nm, "_refund_count"}, refunds.size(), n);
      if (n > 0 && refunds.size() > 0) check({nm, "_refund_value"}, refunds[0], amt);
      refunds.delete();
   endtask

   initial begin
      bus.tick = 0; bus.coin_valid = 0; bus.coin_value = '0;
      bus.drink_sel = '0; bus.Cancel = 0; bus.V_sense = 0;
      repeat (2) @(posedge clk3);
      #1;
      chk_en = 1'b1;
      check("reset_state", int'(bus.state), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_refund", int'(bus.refund_valid), 0);
      check("reset_bebida", int'(bus.led_bebida), 0);
      reset_n = 1'b1;
      idle();

      // Nominal vend with change
      coin(2); coin(2); coin(3);
      pick(2'b10);
      check("nom_press", int'(bus.state), 2);
      tick_n(2);
      check("nom_heat", int'(bus.state), 3);
      tick_n(2);
      check("nom_bebida", int'(bus.led_bebida), 2);
      tick_n(4);
      check("nom_disp_held", int'(bus.state), 4);
      tick_n(1);
      check("nom_refund_state", int'(bus.state), 6);
      check("nom_refund_amt", int'(bus.refund_amount), 2);
      idle();
      check("nom_idle", int'(bus.state), 0);
      expect_refunds("nom", 1, 2);

      // Exact payment: no change pulse
      coin(5); pick(2'b01);
      tick_n(2); tick_n(2); tick_n(5);
      check("exact_idle", int'(bus.state), 0);
      idle();
      expect_refunds("exact", 0, 0);

      // Cancel in SALE
      coin(3); cancel();
      check("cancel_sale_amt", int'(bus.refund_amount), 3);
      idle();
      expect_refunds("cancel_sale", 1, 3);

      // Cancel in PRESS: full refund
      coin(7); pick(2'b01); cancel();
      check("cancel_press_amt", int'(bus.refund_amount), 7);
      idle();
      expect_refunds("cancel_press", 1, 7);

      // Cancel in HEAT ignored
      coin(5); pick(2'b10); tick_n(2);
      cancel();
      check("cancel_heat_ignored", int'(bus.state), 3);
      tick_n(2); tick_n(5); idle();
      expect_refunds("cancel_heat", 0, 0);

      // Sale timeout, then restart by coin
      coin(1); tick_n(14);
      check("timeout_wait", int'(bus.state), 1);
      tick_n(1);
      check("timeout_amt", int'(bus.refund_amount), 1);
      idle();
      expect_refunds("timeout", 1, 1);
      coin(1); tick_n(14); coin(1); tick_n(14);
      check("timeout_restart", int'(bus.state), 1);
      tick_n(1);
      check("timeout_restart_amt", int'(bus.refund_amount), 2);
      idle();
      expect_refunds("timeout_restart", 1, 2);

      // Fault in HEAT
      coin(6); pick(2'b01); tick_n(2);
      fault(1);
      check("fault_err", int'(bus.state), 5);
      check("fault_leds", int'({bus.led_press, bus.led_aquec, bus.led_bebida}), 0);
      fault(1); fault(1);
      fault(0);
      check("fault_refund_amt", int'(bus.refund_amount), 6);
      idle();
      check("fault_idle", int'(bus.state), 0);
      expect_refunds("fault", 1, 6);

      // Fault pulse in IDLE
      fault(1);
      check("idle_fault_err", int'(bus.state), 5);
      fault(0);
      check("idle_fault_back", int'(bus.state), 0);
      idle();
      expect_refunds("idle_fault", 0, 0);

      // Invalid selections
      coin(4); pick(2'b11); pick(2'b01);
      check("low_credit_sale", int'(bus.state), 1);
      coin(1); pick(2'b11); pick(2'b00);
      check("multihot_sale", int'(bus.state), 1);
      cancel(); idle();
      expect_refunds("invalid_sel", 1, 5);

      // Credit saturation
      coin(200); coin(100); cancel();
      check("sat_amt", int'(bus.refund_amount), 255);
      idle();
      expect_refunds("sat", 1, 255);

      // Reset during DISP
      coin(7); pick(2'b10); tick_n(2); tick_n(2); tick_n(1);
      check("rst_in_disp", int'(bus.state), 4);
      reset_n = 1'b0;
      idle();
      check("rst_state", int'(bus.state), 0);
      check("rst_outputs", int'({bus.led_press, bus.led_aquec, bus.led_bebida,
                                 bus.refund_valid, bus.busy}), 0);
      reset_n = 1'b1;
      idle(); idle();
      expect_refunds("rst", 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
